// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master: START / repeated START, write byte, read byte and STOP
// commands driving open-drain SCL/SDA enables, with ACK sampling and clock stretching.
module i2c_byte_ctrl #(
  parameter int LOW_CYC  = 125,
  parameter int HIGH_CYC = 71
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_write,
  input  logic       cmd_read,
  input  logic       cmd_stop,
  input  logic       cmd_rd_nack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       ack_err,
  output logic       done,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_t,
  output logic       sda_t
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LOW_END  = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] HIGH_END = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] LOW_MID  = CW'(LOW_CYC / 2);
  localparam logic [CW-1:0] HIGH_MID = CW'(HIGH_CYC / 2);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RS_LO    = 4'd1,
    START_A  = 4'd2,
    START_B  = 4'd3,
    BIT_LO   = 4'd4,
    BIT_HI   = 4'd5,
    ACK_LO   = 4'd6,
    ACK_HI   = 4'd7,
    HOLD     = 4'd8,
    STOP_LO  = 4'd9,
    STOP_HI  = 4'd10,
    STOP_END = 4'd11
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          q_write;
  logic          q_byte;
  logic          q_stop;
  logic          q_nack;
  logic          scl_meta;
  logic          scl_sync;
  logic          sda_meta;
  logic          sda_sync;
  logic          scl_d1;
  logic          scl_d2;
  logic          accept;
  logic          cmd_byte;
  logic          stretch;
  logic          done_nx;
  logic          sda_nx;

  function automatic logic scl_level(input state_t s);
    case (s)
      RS_LO, BIT_LO, ACK_LO, HOLD, STOP_LO: scl_level = 1'b0;
      default:                              scl_level = 1'b1;
    endcase
  endfunction

  assign accept   = cmd_valid && cmd_ready;
  assign cmd_byte = cmd_write || cmd_read;
  // scl_d2 tracks our own release through the same two-flop delay as scl_sync,
  // so only a slave holding SCL low beyond that lag counts as stretching.
  assign stretch  = scl_t && scl_d2 && !scl_sync;

  // Pad synchronisers and delayed copy of the SCL enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      scl_d1   <= 1'b1;
      scl_d2   <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      scl_d1   <= scl_t;
      scl_d2   <= scl_d1;
    end
  end

  // Next-state and completion-pulse decode.
  always_comb begin
    next_state = state;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (cmd_byte || cmd_start)) begin
          next_state = START_A;
        end else if (accept) begin
          done_nx = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RS_LO:   next_state = (cnt == LOW_END)  ? START_A : RS_LO;
      START_A: next_state = (cnt == HIGH_END) ? START_B : START_A;
      START_B: begin
        if (cnt != HIGH_END) begin
          next_state = START_B;
        end else if (q_byte) begin
          next_state = BIT_LO;
        end else if (q_stop) begin
          next_state = STOP_LO;
        end else begin
          next_state = HOLD;
          done_nx    = 1'b1;
        end
      end
      BIT_LO: next_state = (cnt == LOW_END) ? BIT_HI : BIT_LO;
      BIT_HI: begin
        if (cnt != HIGH_END) begin
          next_state = BIT_HI;
        end else if (bit_cnt == 3'd7) begin
          next_state = ACK_LO;
        end else begin
          next_state = BIT_LO;
        end
      end
      ACK_LO: next_state = (cnt == LOW_END) ? ACK_HI : ACK_LO;
      ACK_HI: begin
        if (cnt != HIGH_END) begin
          next_state = ACK_HI;
        end else if (q_stop) begin
          next_state = STOP_LO;
        end else begin
          next_state = HOLD;
          done_nx    = 1'b1;
        end
      end
      HOLD: begin
        if (!accept) begin
          next_state = HOLD;
        end else if (cmd_start) begin
          next_state = RS_LO;
        end else if (cmd_byte) begin
          next_state = BIT_LO;
        end else if (cmd_stop) begin
          next_state = STOP_LO;
        end else begin
          done_nx = 1'b1;
        end
      end
      STOP_LO: next_state = (cnt == LOW_END)  ? STOP_HI : STOP_LO;
      STOP_HI: next_state = (cnt == HIGH_END) ? STOP_END : STOP_HI;
      STOP_END: begin
        if (cnt == HIGH_END) begin
          next_state = IDLE;
          done_nx    = 1'b1;
        end else begin
          next_state = STOP_END;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // SDA enable: fixed levels on START/STOP state entry, mid-low updates for bits.
  always_comb begin
    sda_nx = sda_t;
    if (next_state != state) begin
      case (next_state)
        IDLE, RS_LO, START_A, STOP_END: sda_nx = 1'b1;
        START_B, STOP_LO, STOP_HI:      sda_nx = 1'b0;
        default:                        sda_nx = sda_t;
      endcase
    end else if (state == BIT_LO && cnt == LOW_MID) begin
      sda_nx = q_write ? shreg[7] : 1'b1;
    end else if (state == ACK_LO && cnt == LOW_MID) begin
      sda_nx = q_write ? 1'b1 : q_nack;
    end else begin
      sda_nx = sda_t;
    end
  end

  // State, phase counter, command capture, data path and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      q_write   <= 1'b0;
      q_byte    <= 1'b0;
      q_stop    <= 1'b0;
      q_nack    <= 1'b0;
      rd_data   <= 8'h00;
      ack_err   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      scl_t     <= 1'b1;
      sda_t     <= 1'b1;
    end else begin
      state     <= next_state;
      scl_t     <= scl_level(next_state);
      sda_t     <= sda_nx;
      done      <= done_nx;
      busy      <= (next_state != IDLE);
      cmd_ready <= (next_state == IDLE) || (next_state == HOLD);
      if ((next_state != state) || stretch) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        q_write <= cmd_write;
        q_byte  <= cmd_byte;
        q_stop  <= cmd_stop;
        q_nack  <= cmd_rd_nack;
        shreg   <= wr_data;
        bit_cnt <= 3'd0;
        ack_err <= 1'b0;
      end else if (state == BIT_HI && next_state != BIT_HI) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == BIT_HI && cnt == HIGH_MID && !q_write) begin
        rd_data <= {rd_data[6:0], sda_sync};
      end
      if (state == ACK_HI && cnt == HIGH_MID && q_write) begin
        ack_err <= sda_sync;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Directed bench for i2c_byte_ctrl with a small behavioural I2C slave, bus
// monitor and a programmable clock-stretch injector.
module tb_i2c_byte_ctrl;

  localparam int M_REL  = 0;
  localparam int M_WACK = 1;
  localparam int M_READ = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid, cmd_ready, cmd_start, cmd_write, cmd_read, cmd_stop, cmd_rd_nack;
  logic [7:0] wr_data, rd_data;
  logic       ack_err, done, busy;
  logic       scl_i, sda_i, scl_t, sda_t;

  int         n_tests = 0;
  int         n_fail  = 0;

  int         mode = M_REL;
  logic [7:0] sdata = 8'h00;
  int         stretch_target = -1;

  int         cur_p = 0;
  int         bcnt = 0;
  bit         active = 1'b0;
  logic       stretch = 1'b0;
  int         stretch_left = 0;
  int         rise_total = 0;
  int         hi_fall = 0;
  int         hi_rise = 0;
  int         low_total = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [7:0] cap_byte = 8'h00;
  logic       cap_ack = 1'b1;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       slave_sda;

  always #5 CLK = ~CLK;

  assign scl_i = scl_t & ~stretch;
  assign sda_i = sda_t & slave_sda;

  i2c_byte_ctrl #(.LOW_CYC(125), .HIGH_CYC(71)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
    .cmd_stop(cmd_stop), .cmd_rd_nack(cmd_rd_nack),
    .wr_data(wr_data), .rd_data(rd_data), .ack_err(ack_err),
    .done(done), .busy(busy),
    .scl_i(scl_i), .sda_i(sda_i), .scl_t(scl_t), .sda_t(sda_t)
  );

  always_comb begin
    slave_sda = 1'b1;
    if (active && mode == M_READ && cur_p < 8) slave_sda = sdata[7 - cur_p];
    else if (active && mode == M_WACK && cur_p == 8) slave_sda = 1'b0;
  end

  // Bus monitor and slave bit tracker, sampled mid-cycle.
  always @(negedge CLK) begin
    if (scl_t == 1'b0 || sda_t == 1'b0) low_total++;
    if (prev_scl && scl_t) begin
      if (prev_sda && !sda_i) begin
        hi_fall++;
        bcnt   = 0;
        active = 1'b1;
      end else if (!prev_sda && sda_i) begin
        hi_rise++;
      end
    end
    if (!prev_scl && scl_t) begin
      rise_total++;
      mon_sh = {mon_sh[6:0], sda_i};
      if (cur_p == 7) cap_byte = mon_sh;
      if (cur_p == 8) cap_ack = sda_i;
      if (rise_total == stretch_target) begin
        stretch      = 1'b1;
        stretch_left = 500;
      end
    end else if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) stretch = 1'b0;
    end
    if (prev_scl && !scl_t) begin
      if (cur_p == 8 && mode == M_READ && cap_ack) active = 1'b0;
      cur_p = bcnt;
      bcnt  = (bcnt == 8) ? 0 : bcnt + 1;
    end
    prev_scl = scl_t;
    prev_sda = sda_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic w, input logic r, input logic p,
                      input logic nk, input logic [7:0] d);
    cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p;
    cmd_rd_nack = nk; wr_data = d; cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
    cmd_read = 1'b0; cmd_stop = 1'b0; cmd_rd_nack = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  initial begin
    int n, f0, r0, l0, k;
    RST = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
    cmd_read = 1'b0; cmd_stop = 1'b0; cmd_rd_nack = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_scl_t", scl_t, 1);
    check("rst_sda_t", sda_t, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_ack_err", ack_err, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Stop-only in IDLE: immediate done, no bus activity
    l0 = low_total;
    send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("stoponly_done", done, 1);
    check("stoponly_busy", busy, 0);
    @(posedge CLK); #1;
    check("stoponly_pulse", done, 0);
    repeat (20) @(posedge CLK);
    #1;
    check("stoponly_lines", low_total - l0, 0);

    // Write 0xA5 with START, no STOP, slave ACKs
    mode = M_WACK; f0 = hi_fall; r0 = hi_rise;
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    check("wr_busy_rise", busy, 1);
    check("wr_ready_low", cmd_ready, 0);
    wait_done(4000, n);
    check("wr_done_cycles", n, 1906);
    check("wr_ack_err", ack_err, 0);
    check("wr_busy_hold", busy, 1);
    check("wr_ready_hold", cmd_ready, 1);
    check("wr_scl_low_hold", scl_t, 0);
    check("wr_sda_bits", cap_byte, 8'hA5);
    check("wr_ack_bit", cap_ack, 0);
    check("wr_start_cnt", hi_fall - f0, 1);
    check("wr_stable_hi", hi_rise - r0, 0);
    @(posedge CLK); #1;
    check("wr_done_pulse", done, 0);

    // Read 0xC3 from HOLD with NACK, slave stretches 3rd bit high phase 500 cycles
    mode = M_READ; sdata = 8'hC3; stretch_target = rise_total + 3;
    send(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    wait_done(5000, n);
    stretch_target = -1;
    check("str_done_cycles", n, 1764 + 502);
    check("str_rd_data", rd_data, 8'hC3);
    check("str_line_byte", cap_byte, 8'hC3);
    check("str_nack_bit", cap_ack, 1);
    check("str_ack_err", ack_err, 0);
    @(posedge CLK); #1;

    // Repeated START, read 0x5A with NACK and STOP
    sdata = 8'h5A; f0 = hi_fall; r0 = hi_rise;
    send(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    wait_done(5000, n);
    check("rs_done_cycles", n, 267 + 1764 + 267);
    check("rs_rd_data", rd_data, 8'h5A);
    check("rs_start_cnt", hi_fall - f0, 1);
    check("rs_stop_cnt", hi_rise - r0, 1);
    check("rs_nack_bit", cap_ack, 1);
    check("rs_ack_err", ack_err, 0);
    check("rs_busy", busy, 0);
    check("rs_lines", {scl_t, sda_t}, 2'b11);
    @(posedge CLK); #1;

    // Write 0x3C with START and STOP, slave NACKs
    mode = M_REL; r0 = hi_rise;
    send(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
    wait_done(4000, n);
    check("nk_done_cycles", n, 142 + 1764 + 267);
    check("nk_ack_err", ack_err, 1);
    check("nk_busy", busy, 0);
    check("nk_sda_bits", cap_byte, 8'h3C);
    check("nk_stop_cnt", hi_rise - r0, 1);
    @(posedge CLK); #1;

    // Reset in the low phase of bit 5 of a write
    mode = M_WACK; r0 = rise_total;
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    k = 0;
    while (rise_total < r0 + 4 && k < 3000) begin
      @(posedge CLK); #1;
      k++;
    end
    while (scl_t !== 1'b0 && k < 3000) begin
      @(posedge CLK); #1;
      k++;
    end
    check("mid_reach_bit5", (k < 3000), 1);
    repeat (100) @(posedge CLK);
    #1;
    check("mid_scl_low", scl_t, 0);
    check("mid_sda_low", sda_t, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("mid_rst_scl_t", scl_t, 1);
    check("mid_rst_sda_t", sda_t, 1);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_data", rd_data, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
